data_mover_bram_mac_n: RTL and testbench
========================================

Name: data_mover_bram_mac_n

Overview:
Parametrised successor to the two-lane BRAM data mover. It streams i_num_cnt packed words from a node BRAM and a weight BRAM and runs NUM_CORE signed MAC lanes in parallel. It then adds a per-lane bias read from a bias BRAM, applies optional ReLU, and writes the NUM_CORE results back to a result BRAM as well as exposing them on a flat output bus. It sits between the CPU-loaded TDP BRAMs and the result readback path, and is controlled through the same run/idle/done handshake.

Parameters:
NUM_CORE, 2, number of parallel MAC lanes (≥1)
IN_DATA_WIDTH, 16, signed lane width in BRAM words
DWIDTH, NUM_CORE*IN_DATA_WIDTH, BRAM data width
ACC_WIDTH, 32, signed accumulator/result width per lane (≥2*IN_DATA_WIDTH)
AWIDTH, 12, BRAM address width
MEM_SIZE, 4096, BRAM depth
CNT_BIT, 31, width of i_num_cnt

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
i_run  in  1  start pulse, sampled only in IDLE
i_num_cnt  in  CNT_BIT  number of words to accumulate (0..MEM_SIZE)
i_relu_en  in  1  ReLU enable, latched with i_run
o_idle  out  1  high in IDLE
o_read  out  1  high in READ
o_write  out  1  high in WRITE
o_done  out  1  one-cycle pulse in DONE
addr_node/ce_node/we_node  out  AWIDTH/1/1  node BRAM port; we_node is tied 0
q_node  in  DWIDTH  node read data
addr_wegt/ce_wegt/we_wegt  out  AWIDTH/1/1  weight BRAM port; we_wegt is tied 0
q_wegt  in  DWIDTH  weight read data
addr_bias/ce_bias  out  AWIDTH/1  bias BRAM port
q_bias  in  DWIDTH  bias read data
addr_rslt/ce_rslt/we_rslt  out  AWIDTH/1/1  result BRAM write port
d_rslt  out  ACC_WIDTH  result write data
o_result  out  NUM_CORE*ACC_WIDTH  final results; lane k at bits [(k+1)*ACC_WIDTH-1 : k*ACC_WIDTH]

Behaviour:
- Reset: state goes to IDLE. All accumulators, o_result, addr_*, ce_*, we_*, d_rslt, o_read, o_write and o_done go to 0. o_idle goes to 1. Reset mid-operation aborts immediately, and no further BRAM writes occur.
- Lane packing in BRAM words: lane k = word[DWIDTH-1-k*IN_DATA_WIDTH -: IN_DATA_WIDTH], so lane 0 occupies the MSBs.
- BRAM read latency is 1 cycle: q is valid the cycle after ce/addr.
- FSM states: IDLE → READ → DRAIN → BIAS → WRITE → DONE → IDLE.
  - IDLE: on i_run, latch i_num_cnt as N and latch i_relu_en. Clear all accumulators and o_result. If N=0, go to DRAIN; otherwise go to READ.
  - READ: N cycles. ce_node=ce_wegt=1, addr = 0..N-1 incrementing each cycle.
  - DRAIN: 3 cycles to flush the pipeline (q register → product register → accumulate).
  - BIAS: 2 cycles. Cycle 1 drives ce_bias=1, addr_bias=0. Cycle 2 computes each lane as acc_k + sign-extended bias lane k, then applies ReLU if enabled (negative → 0), and registers the result into o_result.
  - WRITE: NUM_CORE cycles. ce_rslt=we_rslt=1, addr_rslt=k, d_rslt=o_result lane k, for k = 0..NUM_CORE-1.
  - DONE: 1 cycle, o_done=1, then go to IDLE.
- Latency: the i_run sampling edge is cycle 0. o_done is high in cycle N+NUM_CORE+6. For N=0 it is high in cycle NUM_CORE+6.
- Arithmetic: signed IN×IN product is sign-extended to ACC_WIDTH. The accumulator wraps modulo 2^ACC_WIDTH, with no saturation.
- i_run outside IDLE is ignored.
- A value of i_num_cnt > MEM_SIZE is clamped to MEM_SIZE.
- o_result holds its value from the BIAS cycle 2 until the next accepted i_run or reset.
- ce_* and we_* are 0 outside their owning states.

Test Plan:
1. NUM_CORE=2, N=4; node words {1,2}, weight words {3,4}, bias word {10,-5}, relu off → o_result lane0=22, lane1=27; result BRAM[0]=22, [1]=27; o_done exactly 12 cycles after run.
2. N=4; node {-1,2}, weight {3,-4}, bias {0,0}: relu off → lanes -12 and -32; repeat with relu on → lanes 0 and 0.
3. N=0, bias {7,-3}, relu off → lanes 7 and -3 (0xFFFFFFFD); o_read never asserts; o_done at cycle 8.
4. N=MEM_SIZE=4096; all node and weight lanes 1; bias {0,1} → lanes 4096 and 4097; addr_node reaches 4095 with no wrap to 0.
5. A second i_run pulse during READ is ignored: a single o_done pulse, results identical to scenario 1.
6. Assert reset in DRAIN → next cycle o_idle=1, o_result=0, and no we_rslt assertion ever occurs; a following run reproduces scenario 1.

Source files
------------

// File: rtl/data_mover_bram_mac_n.sv
// NUM_CORE-lane signed MAC data mover: streams node/weight BRAM words, adds a
// per-lane bias, applies optional ReLU and writes lane results to the result BRAM.
module data_mover_bram_mac_n #(
  parameter int unsigned NUM_CORE      = 2,
  parameter int unsigned IN_DATA_WIDTH = 16,
  parameter int unsigned DWIDTH        = NUM_CORE * IN_DATA_WIDTH,
  parameter int unsigned ACC_WIDTH     = 32,
  parameter int unsigned AWIDTH        = 12,
  parameter int unsigned MEM_SIZE      = 4096,
  parameter int unsigned CNT_BIT       = 31
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_run,
  input  logic [CNT_BIT-1:0]            i_num_cnt,
  input  logic                          i_relu_en,
  output logic                          o_idle,
  output logic                          o_read,
  output logic                          o_write,
  output logic                          o_done,
  output logic [AWIDTH-1:0]             addr_node,
  output logic                          ce_node,
  output logic                          we_node,
  input  logic [DWIDTH-1:0]             q_node,
  output logic [AWIDTH-1:0]             addr_wegt,
  output logic                          ce_wegt,
  output logic                          we_wegt,
  input  logic [DWIDTH-1:0]             q_wegt,
  output logic [AWIDTH-1:0]             addr_bias,
  output logic                          ce_bias,
  input  logic [DWIDTH-1:0]             q_bias,
  output logic [AWIDTH-1:0]             addr_rslt,
  output logic                          ce_rslt,
  output logic                          we_rslt,
  output logic [ACC_WIDTH-1:0]          d_rslt,
  output logic [NUM_CORE*ACC_WIDTH-1:0] o_result
);

  localparam int unsigned CNT_W = $clog2(MEM_SIZE) + 1;
  localparam int unsigned RES_W = NUM_CORE * ACC_WIDTH;
  localparam int unsigned PRD_W = 2 * IN_DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_DRAIN, S_BIAS, S_WRITE, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     n_q, n_clamp_c;
  logic                 relu_q;
  logic                 accept_c;

  logic                 o_idle_q, o_read_q, o_write_q, o_done_q;
  logic                 ce_node_q, ce_bias_q, ce_rslt_q, we_rslt_q;
  logic [AWIDTH-1:0]    addr_rd_q, addr_rslt_q;
  logic [ACC_WIDTH-1:0] d_rslt_q;
  logic                 o_idle_d, o_read_d, o_write_d, o_done_d;
  logic                 ce_node_d, ce_bias_d, ce_rslt_d, we_rslt_d;
  logic [AWIDTH-1:0]    addr_rd_d, addr_rslt_d;
  logic [ACC_WIDTH-1:0] d_rslt_d;

  logic                 rd_vld_q, prod_vld_q;
  logic [ACC_WIDTH-1:0] prod_q [NUM_CORE];
  logic [ACC_WIDTH-1:0] prod_c [NUM_CORE];
  logic [ACC_WIDTH-1:0] acc_q  [NUM_CORE];
  logic [RES_W-1:0]     res_q, res_d;

  assign accept_c  = (state_q == S_IDLE) && i_run;
  assign n_clamp_c = (i_num_cnt > CNT_BIT'(MEM_SIZE)) ? CNT_W'(MEM_SIZE) : CNT_W'(i_num_cnt);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; cnt_q tracks the cycle index within the current state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (i_run) state_d = (n_clamp_c == '0) ? S_DRAIN : S_READ;
      end
      S_READ:  if (cnt_q == n_q - CNT_W'(1))          begin state_d = S_DRAIN; cnt_d = '0; end
      S_DRAIN: if (cnt_q == CNT_W'(2))                begin state_d = S_BIAS;  cnt_d = '0; end
      S_BIAS:  if (cnt_q == CNT_W'(1))                begin state_d = S_WRITE; cnt_d = '0; end
      S_WRITE: if (cnt_q == CNT_W'(NUM_CORE - 1))     begin state_d = S_DONE;  cnt_d = '0; end
      S_DONE:  begin state_d = S_IDLE; cnt_d = '0; end
      default: begin state_d = S_IDLE; cnt_d = '0; end
    endcase
  end

  // Output decode from the next state so the registered outputs align with it
  always_comb begin
    o_idle_d    = (state_d == S_IDLE);
    o_read_d    = (state_d == S_READ);
    o_write_d   = (state_d == S_WRITE);
    o_done_d    = (state_d == S_DONE);
    ce_node_d   = (state_d == S_READ);
    addr_rd_d   = (state_d == S_READ) ? AWIDTH'(cnt_d) : '0;
    ce_bias_d   = (state_d == S_BIAS) && (cnt_d == '0);
    ce_rslt_d   = (state_d == S_WRITE);
    we_rslt_d   = (state_d == S_WRITE);
    addr_rslt_d = (state_d == S_WRITE) ? AWIDTH'(cnt_d) : '0;
    d_rslt_d    = '0;
    for (int k = 0; k < int'(NUM_CORE); k++) begin
      if ((state_d == S_WRITE) && (cnt_d == CNT_W'(k)))
        d_rslt_d = res_d[k*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_idle_q    <= 1'b1;
      o_read_q    <= 1'b0;
      o_write_q   <= 1'b0;
      o_done_q    <= 1'b0;
      ce_node_q   <= 1'b0;
      addr_rd_q   <= '0;
      ce_bias_q   <= 1'b0;
      ce_rslt_q   <= 1'b0;
      we_rslt_q   <= 1'b0;
      addr_rslt_q <= '0;
      d_rslt_q    <= '0;
    end else begin
      o_idle_q    <= o_idle_d;
      o_read_q    <= o_read_d;
      o_write_q   <= o_write_d;
      o_done_q    <= o_done_d;
      ce_node_q   <= ce_node_d;
      addr_rd_q   <= addr_rd_d;
      ce_bias_q   <= ce_bias_d;
      ce_rslt_q   <= ce_rslt_d;
      we_rslt_q   <= we_rslt_d;
      addr_rslt_q <= addr_rslt_d;
      d_rslt_q    <= d_rslt_d;
    end
  end

  // Per-lane signed products and bias/ReLU stage
  always_comb begin
    logic signed [IN_DATA_WIDTH-1:0] n_l, w_l, b_l;
    logic signed [PRD_W-1:0]         p_l;
    logic        [ACC_WIDTH-1:0]     sum_l;
    res_d = res_q;
    for (int k = 0; k < int'(NUM_CORE); k++) begin
      n_l       = q_node[DWIDTH-1-k*IN_DATA_WIDTH -: IN_DATA_WIDTH];
      w_l       = q_wegt[DWIDTH-1-k*IN_DATA_WIDTH -: IN_DATA_WIDTH];
      b_l       = q_bias[DWIDTH-1-k*IN_DATA_WIDTH -: IN_DATA_WIDTH];
      p_l       = PRD_W'(n_l) * PRD_W'(w_l);
      prod_c[k] = ACC_WIDTH'(p_l);
      sum_l     = acc_q[k] + ACC_WIDTH'(b_l);
      if (relu_q && sum_l[ACC_WIDTH-1]) sum_l = '0;
      if (accept_c)
        res_d[k*ACC_WIDTH +: ACC_WIDTH] = '0;
      else if ((state_q == S_BIAS) && (cnt_q == CNT_W'(1)))
        res_d[k*ACC_WIDTH +: ACC_WIDTH] = sum_l;
    end
  end

  // Datapath pipeline: BRAM q -> product register -> accumulator
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q        <= '0;
      relu_q     <= 1'b0;
      rd_vld_q   <= 1'b0;
      prod_vld_q <= 1'b0;
      res_q      <= '0;
      for (int k = 0; k < int'(NUM_CORE); k++) begin
        prod_q[k] <= '0;
        acc_q[k]  <= '0;
      end
    end else begin
      rd_vld_q   <= ce_node_q;
      prod_vld_q <= rd_vld_q;
      res_q      <= res_d;
      if (accept_c) begin
        n_q    <= n_clamp_c;
        relu_q <= i_relu_en;
      end
      for (int k = 0; k < int'(NUM_CORE); k++) begin
        if (rd_vld_q) prod_q[k] <= prod_c[k];
        if (accept_c)        acc_q[k] <= '0;
        else if (prod_vld_q) acc_q[k] <= acc_q[k] + prod_q[k];
      end
    end
  end

  assign o_idle    = o_idle_q;
  assign o_read    = o_read_q;
  assign o_write   = o_write_q;
  assign o_done    = o_done_q;
  assign addr_node = addr_rd_q;
  assign ce_node   = ce_node_q;
  assign we_node   = 1'b0;
  assign addr_wegt = addr_rd_q;
  assign ce_wegt   = ce_node_q;
  assign we_wegt   = 1'b0;
  assign addr_bias = '0;
  assign ce_bias   = ce_bias_q;
  assign addr_rslt = addr_rslt_q;
  assign ce_rslt   = ce_rslt_q;
  assign we_rslt   = we_rslt_q;
  assign d_rslt    = d_rslt_q;
  assign o_result  = res_q;

endmodule

// File: tb/tb_data_mover_bram_mac_n.sv
// Bench for data_mover_bram_mac_n: BRAM models plus a sum-of-products reference.
module tb_data_mover_bram_mac_n;

  localparam int NC  = 2;
  localparam int IW  = 16;
  localparam int DW  = NC * IW;
  localparam int AW  = 32;
  localparam int ADW = 12;
  localparam int MS  = 4096;
  localparam int CB  = 31;

  logic clk = 1'b0;
  logic reset;
  logic i_run;
  logic [CB-1:0] i_num_cnt;
  logic i_relu_en;
  logic o_idle, o_read, o_write, o_done;
  logic [ADW-1:0] addr_node, addr_wegt, addr_bias, addr_rslt;
  logic ce_node, we_node, ce_wegt, we_wegt, ce_bias, ce_rslt, we_rslt;
  logic [DW-1:0] q_node, q_wegt, q_bias;
  logic [AW-1:0] d_rslt;
  logic [NC*AW-1:0] o_result;

  logic [DW-1:0] node_mem [MS];
  logic [DW-1:0] wegt_mem [MS];
  logic [DW-1:0] bias_mem [MS];
  logic [AW-1:0] rslt_mem [NC];

  int checks = 0;
  int errors = 0;
  int wr_cnt, done_cnt, read_cnt, nread, addr_err, last_addr;

  always #5 clk = ~clk;

  data_mover_bram_mac_n dut (
    .clk(clk), .reset(reset), .i_run(i_run), .i_num_cnt(i_num_cnt), .i_relu_en(i_relu_en),
    .o_idle(o_idle), .o_read(o_read), .o_write(o_write), .o_done(o_done),
    .addr_node(addr_node), .ce_node(ce_node), .we_node(we_node), .q_node(q_node),
    .addr_wegt(addr_wegt), .ce_wegt(ce_wegt), .we_wegt(we_wegt), .q_wegt(q_wegt),
    .addr_bias(addr_bias), .ce_bias(ce_bias), .q_bias(q_bias),
    .addr_rslt(addr_rslt), .ce_rslt(ce_rslt), .we_rslt(we_rslt), .d_rslt(d_rslt),
    .o_result(o_result)
  );

  // One-cycle-latency BRAM read ports
  always @(posedge clk) begin
    if (ce_node) q_node <= node_mem[addr_node];
    if (ce_wegt) q_wegt <= wegt_mem[addr_wegt];
    if (ce_bias) q_bias <= bias_mem[addr_bias];
  end

  // Observe writes, pulses and the read address sequence mid-cycle
  always @(negedge clk) begin
    if (ce_rslt && we_rslt) begin
      wr_cnt++;
      if (int'(addr_rslt) < NC) rslt_mem[addr_rslt] = d_rslt;
    end
    if (o_done) done_cnt++;
    if (o_read) read_cnt++;
    if (ce_node) begin
      if (int'(addr_node) != nread) addr_err++;
      last_addr = int'(addr_node);
      nread++;
    end
  end

  function automatic logic [AW-1:0] model_lane(input int n, input int k, input bit relu);
    longint acc;
    logic [DW-1:0] wn, ww, wb;
    logic [IW-1:0] ln, lw, lb;
    logic [AW-1:0] r;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      wn = node_mem[i];
      ww = wegt_mem[i];
      ln = wn[DW-1-k*IW -: IW];
      lw = ww[DW-1-k*IW -: IW];
      acc += longint'($signed(ln)) * longint'($signed(lw));
    end
    wb = bias_mem[0];
    lb = wb[DW-1-k*IW -: IW];
    acc += longint'($signed(lb));
    r = acc[AW-1:0];
    if (relu && r[AW-1]) r = '0;
    return r;
  endfunction

  function automatic logic [AW-1:0] res_lane(input int k);
    logic [NC*AW-1:0] v;
    v = o_result;
    return v[k*AW +: AW];
  endfunction

  task automatic fill(input int n, input logic [DW-1:0] nw, input logic [DW-1:0] ww,
                      input logic [DW-1:0] bw);
    for (int i = 0; i < n; i++) begin
      node_mem[i] = nw;
      wegt_mem[i] = ww;
    end
    bias_mem[0] = bw;
  endtask

  // Issue one run and step until o_done; done_cyc counts edges after the sampling edge
  task automatic do_run(input int n_in, input bit relu, input bit extra_run, output int done_cyc);
    int cyc;
    wr_cnt = 0; done_cnt = 0; read_cnt = 0; nread = 0; addr_err = 0; last_addr = -1;
    for (int k = 0; k < NC; k++) rslt_mem[k] = 32'hDEAD_BEEF;
    done_cyc = -1;
    @(negedge clk);
    i_run = 1'b1; i_num_cnt = CB'(n_in); i_relu_en = relu;
    @(posedge clk);
    @(negedge clk);
    i_run = 1'b0;
    cyc = 1;
    while (cyc < 6000) begin
      if (extra_run && cyc == 2) i_run = 1'b1;
      if (extra_run && cyc == 3) i_run = 1'b0;
      if (o_done) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_run(input string name, input int n, input bit relu, input int done_cyc);
    logic [AW-1:0] exp_l;
    for (int k = 0; k < NC; k++) begin
      exp_l = model_lane(n, k, relu);
      checks++;
      if (res_lane(k) !== exp_l) begin
        errors++;
        $display("FAIL %s o_result lane%0d got %h exp %h", name, k, res_lane(k), exp_l);
      end
      checks++;
      if (rslt_mem[k] !== exp_l) begin
        errors++;
        $display("FAIL %s rslt_mem[%0d] got %h exp %h", name, k, rslt_mem[k], exp_l);
      end
    end
    checks++;
    if (done_cyc != n + NC + 6) begin
      errors++;
      $display("FAIL %s done_cycle got %0d exp %0d", name, done_cyc, n + NC + 6);
    end
    checks++;
    if (done_cnt != 1 || wr_cnt != NC) begin
      errors++;
      $display("FAIL %s pulses done=%0d writes=%0d exp 1 %0d", name, done_cnt, wr_cnt, NC);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; i_run = 1'b0; i_num_cnt = '0; i_relu_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_idle !== 1'b1 || o_done !== 1'b0 || o_read !== 1'b0 || o_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags idle=%b done=%b read=%b write=%b exp 1 0 0 0",
               o_idle, o_done, o_read, o_write);
    end
    checks++;
    if (o_result !== '0 || ce_node !== 1'b0 || ce_rslt !== 1'b0 || we_rslt !== 1'b0 ||
        ce_bias !== 1'b0 || d_rslt !== '0) begin
      errors++;
      $display("FAIL reset_outputs result=%h ce_node=%b ce_rslt=%b we_rslt=%b exp zeros",
               o_result, ce_node, ce_rslt, we_rslt);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int dc;
    fill(4, {16'd1, 16'd2}, {16'd3, 16'd4}, {16'd10, -16'sd5});
    do_run(4, 1'b0, 1'b0, dc);
    check_run("basic", 4, 1'b0, dc);
    checks++;
    if (res_lane(0) !== 32'd22 || res_lane(1) !== 32'd27) begin
      errors++;
      $display("FAIL basic_const got %0d %0d exp 22 27", res_lane(0), res_lane(1));
    end
  endtask

  task automatic test_relu();
    int dc;
    fill(4, {-16'sd1, 16'd2}, {16'd3, -16'sd4}, 32'd0);
    do_run(4, 1'b0, 1'b0, dc);
    check_run("neg_norelu", 4, 1'b0, dc);
    checks++;
    if (res_lane(0) !== -32'sd12 || res_lane(1) !== -32'sd32) begin
      errors++;
      $display("FAIL neg_const got %h %h exp fffffff4 ffffffe0", res_lane(0), res_lane(1));
    end
    do_run(4, 1'b1, 1'b0, dc);
    check_run("neg_relu", 4, 1'b1, dc);
  endtask

  task automatic test_zero_count();
    int dc;
    bias_mem[0] = {16'd7, -16'sd3};
    do_run(0, 1'b0, 1'b0, dc);
    check_run("zero_n", 0, 1'b0, dc);
    checks++;
    if (read_cnt != 0 || nread != 0 || res_lane(1) !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL zero_n_read read_cycles=%0d lane1=%h exp 0 fffffffd", read_cnt, res_lane(1));
    end
  endtask

  task automatic test_full_and_clamp();
    int dc;
    fill(MS, {16'd1, 16'd1}, {16'd1, 16'd1}, {16'd0, 16'd1});
    do_run(MS, 1'b0, 1'b0, dc);
    check_run("full", MS, 1'b0, dc);
    checks++;
    if (nread != MS || last_addr != MS - 1 || addr_err != 0) begin
      errors++;
      $display("FAIL full_addr reads=%0d last=%0d addr_err=%0d exp %0d %0d 0",
               nread, last_addr, addr_err, MS, MS - 1);
    end
    do_run(5000, 1'b0, 1'b0, dc);
    check_run("clamp", MS, 1'b0, dc);
  endtask

  task automatic test_random();
    int dc, n;
    bit relu;
    for (int it = 0; it < 6; it++) begin
      n = int'($urandom_range(1, 24));
      relu = 1'($urandom_range(0, 1));
      for (int i = 0; i < 24; i++) begin
        node_mem[i] = DW'($urandom);
        wegt_mem[i] = DW'($urandom);
      end
      bias_mem[0] = DW'($urandom);
      do_run(n, relu, 1'b0, dc);
      check_run("random", n, relu, dc);
      checks++;
      if (addr_err != 0 || nread != n) begin
        errors++;
        $display("FAIL random_addr reads=%0d addr_err=%0d exp %0d 0", nread, addr_err, n);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dc;
    fill(4, {16'd1, 16'd2}, {16'd3, 16'd4}, {16'd10, -16'sd5});
    do_run(4, 1'b0, 1'b1, dc);
    check_run("rerun_ignored", 4, 1'b0, dc);
    checks++;
    if (nread != 4) begin
      errors++;
      $display("FAIL rerun_reads got %0d exp 4", nread);
    end
  endtask

  task automatic test_reset_mid();
    int dc;
    fill(4, {16'd1, 16'd2}, {16'd3, 16'd4}, {16'd10, -16'sd5});
    wr_cnt = 0;
    @(negedge clk);
    i_run = 1'b1; i_num_cnt = CB'(4); i_relu_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    i_run = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (o_idle !== 1'b1 || o_result !== '0) begin
      errors++;
      $display("FAIL reset_mid idle=%b result=%h exp 1 0", o_idle, o_result);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (wr_cnt != 0) begin
      errors++;
      $display("FAIL reset_mid_writes got %0d exp 0", wr_cnt);
    end
    do_run(4, 1'b0, 1'b0, dc);
    check_run("after_reset", 4, 1'b0, dc);
  endtask

  initial begin
    for (int i = 0; i < MS; i++) begin
      node_mem[i] = '0;
      wegt_mem[i] = '0;
      bias_mem[i] = '0;
    end
    test_reset();
    test_basic();
    test_relu();
    test_zero_count();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_full_and_clamp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
